// File: rtl/hcube_path_walker_if.sv
// Descriptor-in / hop-out bundle between the path generator, the walker and
// the router injection logic.
interface hcube_path_walker_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_src;
  logic [1:0] cfg_group;
  logic [2:0] cfg_len0;
  logic [1:0] cfg_len1;
  logic [1:0] cfg_len2;
  logic [7:0] cfg_data0;
  logic [5:0] cfg_data1;
  logic [3:0] cfg_data2;
  logic       hop_valid;
  logic       hop_ready;
  logic [1:0] hop_dim;
  logic [3:0] hop_node;
  logic [1:0] hop_seg;
  logic       hop_last;

  // slave: the walker (takes descriptors, produces hops)
  modport slave (
    input  cfg_valid, cfg_src, cfg_group, cfg_len0, cfg_len1, cfg_len2,
           cfg_data0, cfg_data1, cfg_data2, hop_ready,
    output cfg_ready, hop_valid, hop_dim, hop_node, hop_seg, hop_last
  );
  modport master (
    output cfg_valid, cfg_src, cfg_group, cfg_len0, cfg_len1, cfg_len2,
           cfg_data0, cfg_data1, cfg_data2, hop_ready,
    input  cfg_ready, hop_valid, hop_dim, hop_node, hop_seg, hop_last
  );
endinterface

// File: rtl/hcube_path_walker.sv
// Walks a 3-segment hypercube path descriptor and emits one hop
// (flipped dimension + resulting node) per accepted transfer.
module hcube_path_walker #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  hcube_path_walker_if.slave bus,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, CHECK, WALK, FIN} state_e;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [3:0]             cur_node_q, cur_node_d;
  logic [1:0]             group_q, group_d;
  logic [2:0][2:0]        len_q, len_d;
  logic [2:0][3:0][1:0]   dim_q, dim_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             rem_q, rem_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic                   cfg_ready_q, cfg_ready_d, busy_q, busy_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   hop_valid_q, hop_valid_d, hop_last_q, hop_last_d;
  logic [1:0]             hop_dim_q, hop_dim_d, hop_seg_q, hop_seg_d;
  logic [3:0]             hop_node_q, hop_node_d;

  logic                   invalid, do_load, adv;
  logic [3:0]             total, base_node;
  logic [2:0]             start;
  logic [1:0]             nxt_seg, ld_seg, ld_idx;

  always_comb begin
    state_d     = state_q;
    cur_node_d  = cur_node_q;
    group_d     = group_q;
    len_d       = len_q;
    dim_d       = dim_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    stall_d     = stall_q;
    hop_valid_d = hop_valid_q;
    hop_dim_d   = hop_dim_q;
    hop_node_d  = hop_node_q;
    hop_seg_d   = hop_seg_q;
    hop_last_d  = hop_last_q;
    err_d       = 1'b0;
    do_load     = 1'b0;
    ld_seg      = 2'd0;
    ld_idx      = 2'd0;
    base_node   = cur_node_q;

    invalid = (group_q == 2'd0) || (len_q[0] > 3'd4) ||
              (group_q < 2'd2 && len_q[1] != 3'd0) ||
              (group_q < 2'd3 && len_q[2] != 3'd0);
    total   = 4'(len_q[0]) + 4'(len_q[1]) + 4'(len_q[2]);

    // First non-empty segment at or after 'start'; empty segments never cost a cycle.
    start   = (state_q == WALK) ? ({1'b0, seg_q_w()} + 3'd1) : 3'd0;
    nxt_seg = 2'd0;
    for (int k = 2; k >= 0; k--)
      if (k >= int'(start) && len_q[k] != 3'd0) nxt_seg = 2'(k);
    adv = ({1'b0, idx_q} + 3'd1) < len_q[hop_seg_q];

    case (state_q)
      IDLE: if (bus.cfg_valid) begin
        cur_node_d = bus.cfg_src;
        group_d    = bus.cfg_group;
        len_d      = {{1'b0, bus.cfg_len2}, {1'b0, bus.cfg_len1}, bus.cfg_len0};
        dim_d      = {{4'b0, bus.cfg_data2}, {2'b0, bus.cfg_data1}, bus.cfg_data0};
        stall_d    = '0;
        state_d    = CHECK;
      end
      CHECK: begin
        if (invalid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (total == 4'd0) begin
          state_d = FIN;
        end else begin
          do_load    = 1'b1;
          ld_seg     = nxt_seg;
          rem_d      = total;
          hop_last_d = (total == 4'd1);
          state_d    = WALK;
        end
      end
      WALK: begin
        if (bus.hop_ready) begin
          cur_node_d = hop_node_q;
          stall_d    = '0;
          if (hop_last_q) begin
            hop_valid_d = 1'b0;
            state_d     = FIN;
          end else begin
            do_load    = 1'b1;
            base_node  = hop_node_q;
            ld_seg     = adv ? hop_seg_q : nxt_seg;
            ld_idx     = adv ? idx_q + 2'd1 : 2'd0;
            rem_d      = rem_q - 4'd1;
            hop_last_d = (rem_q == 4'd2);
          end
        end else if (TIMEOUT != 0) begin
          if (stall_q + CNT_W'(1) == TO_LIM) begin
            err_d       = 1'b1;
            hop_valid_d = 1'b0;
            stall_d     = '0;
            state_d     = IDLE;
          end else begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      hop_valid_d = 1'b1;
      hop_seg_d   = ld_seg;
      idx_d       = ld_idx;
      hop_dim_d   = dim_q[ld_seg][ld_idx];
      hop_node_d  = base_node ^ (4'b0001 << dim_q[ld_seg][ld_idx]);
    end

    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  function automatic logic [1:0] seg_q_w();
    return hop_seg_q;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_node_q  <= '0;
      group_q     <= '0;
      len_q       <= '0;
      dim_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      stall_q     <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hop_valid_q <= 1'b0;
      hop_last_q  <= 1'b0;
      hop_dim_q   <= '0;
      hop_seg_q   <= '0;
      hop_node_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_node_q  <= cur_node_d;
      group_q     <= group_d;
      len_q       <= len_d;
      dim_q       <= dim_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      stall_q     <= stall_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hop_valid_q <= hop_valid_d;
      hop_last_q  <= hop_last_d;
      hop_dim_q   <= hop_dim_d;
      hop_seg_q   <= hop_seg_d;
      hop_node_q  <= hop_node_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.hop_valid = hop_valid_q;
  assign bus.hop_dim   = hop_dim_q;
  assign bus.hop_node  = hop_node_q;
  assign bus.hop_seg   = hop_seg_q;
  assign bus.hop_last  = hop_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_hcube_path_walker.sv
// Directed bench for hcube_path_walker: hop sequences, backpressure, invalid
// descriptors, stall timeout, empty segments and mid-walk reset.
module tb_hcube_path_walker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;
  int   n_chk = 0;
  int   n_fail = 0;

  hcube_path_walker_if bus();

  hcube_path_walker #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {valid, dim, node, seg, last}
  task automatic chk_hop(input string tag, input logic v, input logic [1:0] d,
                         input logic [3:0] n, input logic [1:0] s, input logic l);
    chk(tag, {6'd0, bus.hop_valid, bus.hop_dim, bus.hop_node, bus.hop_seg, bus.hop_last},
             {6'd0, v, d, n, s, l});
  endtask

  // {cfg_ready, busy, done, err}
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {12'd0, bus.cfg_ready, busy, done, err}, {12'd0, exp});
  endtask

  task automatic send(input logic [3:0] src, input logic [1:0] grp,
                      input logic [2:0] l0, input logic [1:0] l1, input logic [1:0] l2,
                      input logic [7:0] d0, input logic [5:0] d1, input logic [3:0] d2);
    bus.cfg_src = src;  bus.cfg_group = grp;
    bus.cfg_len0 = l0;  bus.cfg_len1 = l1;  bus.cfg_len2 = l2;
    bus.cfg_data0 = d0; bus.cfg_data1 = d1; bus.cfg_data2 = d2;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_src = 4'hf; bus.cfg_data0 = 8'hff;
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_src = '0; bus.cfg_group = '0;
    bus.cfg_len0 = '0; bus.cfg_len1 = '0; bus.cfg_len2 = '0;
    bus.cfg_data0 = '0; bus.cfg_data1 = '0; bus.cfg_data2 = '0;
    bus.hop_ready = 1'b1;

    tick(); tick();
    chk_st("reset_status", 4'b1000);
    chk_hop("reset_hop", 0, 0, 4'd0, 0, 0);
    rst_n = 1'b1;
    tick();

    // 1: src 0, dims 0,1,2 on one segment
    send(4'd0, 2'd1, 3'd3, 2'd0, 2'd0, 8'h24, 6'h0, 4'h0);
    chk_st("t1_check_status", 4'b0100);
    chk_hop("t1_check_nohop", 0, 0, 4'd0, 0, 0);
    tick(); chk_hop("t1_hop0", 1, 2'd0, 4'd1, 2'd0, 0);
    tick(); chk_hop("t1_hop1", 1, 2'd1, 4'd3, 2'd0, 0);
    tick(); chk_hop("t1_hop2", 1, 2'd2, 4'd7, 2'd0, 1);
    tick(); chk_st("t1_done", 4'b0110);
    chk("t1_nohop", {15'd0, bus.hop_valid}, 16'd0);
    tick(); chk_st("t1_idle", 4'b1000);

    // 2: three segments, src 5
    send(4'd5, 2'd3, 3'd2, 2'd1, 2'd1, 8'h04, 6'h02, 4'h3);
    tick(); chk_hop("t2_hop0", 1, 2'd0, 4'd4, 2'd0, 0);
    tick(); chk_hop("t2_hop1", 1, 2'd1, 4'd6, 2'd0, 0);
    tick(); chk_hop("t2_hop2", 1, 2'd2, 4'd2, 2'd1, 0);
    tick(); chk_hop("t2_hop3", 1, 2'd3, 4'd10, 2'd2, 1);
    tick(); chk_st("t2_done", 4'b0110);
    tick(); chk_st("t2_idle", 4'b1000);

    // 3: scenario 1 with hop 2 stalled for 3 cycles
    send(4'd0, 2'd1, 3'd3, 2'd0, 2'd0, 8'h24, 6'h0, 4'h0);
    tick(); chk_hop("t3_hop0", 1, 2'd0, 4'd1, 2'd0, 0);
    tick(); chk_hop("t3_hop1", 1, 2'd1, 4'd3, 2'd0, 0);
    bus.hop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_hop($sformatf("t3_hold%0d", i), 1, 2'd1, 4'd3, 2'd0, 0);
    end
    chk_st("t3_hold_status", 4'b0100);
    bus.hop_ready = 1'b1;
    tick(); chk_hop("t3_hop2", 1, 2'd2, 4'd7, 2'd0, 1);
    tick(); chk_st("t3_done", 4'b0110);
    tick(); chk_st("t3_idle", 4'b1000);

    // 4: invalid descriptors
    send(4'd2, 2'd0, 3'd1, 2'd0, 2'd0, 8'h00, 6'h0, 4'h0);
    chk_st("t4a_check", 4'b0100);
    tick(); chk_st("t4a_err", 4'b1001);
    chk("t4a_nohop", {15'd0, bus.hop_valid}, 16'd0);
    tick(); chk_st("t4a_idle", 4'b1000);
    send(4'd2, 2'd1, 3'd1, 2'd2, 2'd0, 8'h00, 6'h0, 4'h0);
    tick(); chk_st("t4b_err", 4'b1001);
    chk("t4b_nohop", {15'd0, bus.hop_valid}, 16'd0);
    tick(); chk_st("t4b_idle", 4'b1000);

    // 5: timeout after 4 stalled cycles
    bus.hop_ready = 1'b0;
    send(4'd0, 2'd1, 3'd3, 2'd0, 2'd0, 8'h24, 6'h0, 4'h0);
    tick(); chk_hop("t5_stall1", 1, 2'd0, 4'd1, 2'd0, 0);
    for (int i = 2; i <= 4; i++) begin
      tick(); chk_hop($sformatf("t5_stall%0d", i), 1, 2'd0, 4'd1, 2'd0, 0);
      chk_st($sformatf("t5_noerr%0d", i), 4'b0100);
    end
    tick(); chk_st("t5_err", 4'b1001);
    chk("t5_drop", {15'd0, bus.hop_valid}, 16'd0);
    tick(); chk_st("t5_idle", 4'b1000);
    bus.hop_ready = 1'b1;
    send(4'd3, 2'd1, 3'd1, 2'd0, 2'd0, 8'h03, 6'h0, 4'h0);
    tick(); chk_hop("t5_next_hop", 1, 2'd3, 4'd11, 2'd0, 1);
    tick(); chk_st("t5_next_done", 4'b0110);
    tick();

    // 6a: empty segment 0 skipped
    send(4'd0, 2'd2, 3'd0, 2'd2, 2'd0, 8'h00, 6'h07, 4'h0);
    tick(); chk_hop("t6a_hop0", 1, 2'd3, 4'd8, 2'd1, 0);
    tick(); chk_hop("t6a_hop1", 1, 2'd1, 4'd10, 2'd1, 1);
    tick(); chk_st("t6a_done", 4'b0110);
    tick();

    // 6b: all lengths zero
    send(4'd9, 2'd1, 3'd0, 2'd0, 2'd0, 8'h00, 6'h0, 4'h0);
    tick(); chk_st("t6b_done", 4'b0110);
    chk("t6b_nohop", {15'd0, bus.hop_valid}, 16'd0);
    tick(); chk_st("t6b_idle", 4'b1000);

    // 6c: reset in WALK
    bus.hop_ready = 1'b0;
    send(4'd0, 2'd1, 3'd3, 2'd0, 2'd0, 8'h24, 6'h0, 4'h0);
    tick(); chk_hop("t6c_walk", 1, 2'd0, 4'd1, 2'd0, 0);
    rst_n = 1'b0;
    #1;
    chk_hop("t6c_rst_hop", 0, 0, 4'd0, 0, 0);
    chk_st("t6c_rst_status", 4'b1000);
    tick(); tick();
    chk_st("t6c_rst_hold", 4'b1000);
    rst_n = 1'b1;
    bus.hop_ready = 1'b1;
    tick(); chk_st("t6c_after", 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
